// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD engine: FSM state encoding, algorithm
// selectors and a sizing helper for the Stein shift counter.
package gcd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int ALGO_SUB   = 0;
    localparam int ALGO_STEIN = 1;

    // Bits needed to count common factors of two up to WIDTH.
    function automatic int k_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/gcd_step.sv
// One combinational GCD iteration: given the current x/y pair, produce the
// next pair, whether a common factor of two was removed, and whether the
// pair is already terminal (equal, or one of them zero).
module gcd_step
    import gcd_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int ALGO  = ALGO_SUB
) (
    input  logic [WIDTH-1:0] x_i,
    input  logic [WIDTH-1:0] y_i,
    output logic [WIDTH-1:0] x_nxt_o,
    output logic [WIDTH-1:0] y_nxt_o,
    output logic             inc_k_o,
    output logic             terminal_o
);

    logic             x_ge_y_s;
    logic [WIDTH-1:0] sub_x_s;
    logic [WIDTH-1:0] sub_y_s;

    // Larger := larger - smaller; the guard keeps the subtraction from wrapping.
    assign x_ge_y_s = (x_i >= y_i);
    assign sub_x_s  = x_ge_y_s ? (x_i - y_i) : x_i;
    assign sub_y_s  = x_ge_y_s ? y_i : (y_i - x_i);

    // Select the step rule for the configured algorithm and flag terminal pairs.
    always_comb begin
        x_nxt_o    = x_i;
        y_nxt_o    = y_i;
        inc_k_o    = 1'b0;
        terminal_o = (x_i == y_i) || (x_i == {WIDTH{1'b0}}) || (y_i == {WIDTH{1'b0}});
        case (ALGO)
            ALGO_SUB: begin
                x_nxt_o = sub_x_s;
                y_nxt_o = sub_y_s;
            end
            ALGO_STEIN: begin
                case ({x_i[0], y_i[0]})
                    2'b00: begin
                        x_nxt_o = x_i >> 1'b1;
                        y_nxt_o = y_i >> 1'b1;
                        inc_k_o = 1'b1;
                    end
                    2'b01:   x_nxt_o = x_i >> 1'b1;
                    2'b10:   y_nxt_o = y_i >> 1'b1;
                    2'b11: begin
                        x_nxt_o = sub_x_s;
                        y_nxt_o = sub_y_s;
                    end
                    default: begin
                        x_nxt_o = x_i;
                        y_nxt_o = y_i;
                    end
                endcase
            end
            default: begin
                x_nxt_o = sub_x_s;
                y_nxt_o = sub_y_s;
            end
        endcase
    end

endmodule

// File: rtl/gcd_engine.sv
// Autonomous GCD engine with valid/ready handshakes on operand and result
// sides. IDLE accepts a pair, CALC iterates one step per clock, DONE holds
// the result until the sink takes it. abort drops back to IDLE at once
// while leaving the last reported result untouched.
module gcd_engine
    import gcd_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int ALGO  = ALGO_SUB,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             abort,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x_in,
    input  logic [WIDTH-1:0] y_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] gcd_out,
    output logic [CNT_W-1:0] steps_out,
    output logic             zero_err,
    output logic             busy
);

    localparam int K_W = k_width(WIDTH);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [K_W-1:0]   k_q, k_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] gcd_q, gcd_d;
    logic [CNT_W-1:0] steps_q, steps_d;
    logic             zero_err_q, zero_err_d;

    logic [WIDTH-1:0] x_step_s;
    logic [WIDTH-1:0] y_step_s;
    logic             inc_k_s;
    logic             terminal_s;
    logic [WIDTH-1:0] term_val_s;
    logic             both_zero_s;

    gcd_step #(
        .WIDTH (WIDTH),
        .ALGO  (ALGO)
    ) u_step (
        .x_i        (x_q),
        .y_i        (y_q),
        .x_nxt_o    (x_step_s),
        .y_nxt_o    (y_step_s),
        .inc_k_o    (inc_k_s),
        .terminal_o (terminal_s)
    );

    // Terminal value is the nonzero operand (or x when equal); zero when both are zero.
    assign term_val_s  = (x_q == {WIDTH{1'b0}}) ? y_q : x_q;
    assign both_zero_s = (x_q == {WIDTH{1'b0}}) && (y_q == {WIDTH{1'b0}});

    assign gcd_out   = gcd_q;
    assign steps_out = steps_q;
    assign zero_err  = zero_err_q;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; abort overrides every other transition.
    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        state_d = ST_CALC;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_CALC: begin
                    if (terminal_s) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_CALC;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Handshake outputs decoded from the state register only.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state_q)
            ST_IDLE: in_ready  = 1'b1;
            ST_CALC: busy      = 1'b1;
            ST_DONE: out_valid = 1'b1;
            default: in_ready  = 1'b0;
        endcase
    end

    // Datapath next values: latch operands, iterate, or capture the result.
    always_comb begin
        x_d        = x_q;
        y_d        = y_q;
        k_d        = k_q;
        cnt_d      = cnt_q;
        gcd_d      = gcd_q;
        steps_d    = steps_q;
        zero_err_d = zero_err_q;
        if (!abort) begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        x_d   = x_in;
                        y_d   = y_in;
                        k_d   = {K_W{1'b0}};
                        cnt_d = {CNT_W{1'b0}};
                    end else begin
                        x_d = x_q;
                    end
                end
                ST_CALC: begin
                    if (terminal_s) begin
                        gcd_d      = term_val_s << k_q;
                        steps_d    = cnt_q;
                        zero_err_d = both_zero_s;
                    end else begin
                        x_d = x_step_s;
                        y_d = y_step_s;
                        k_d = k_q + K_W'(inc_k_s);
                        if (cnt_q != {CNT_W{1'b1}}) begin
                            cnt_d = cnt_q + CNT_W'(1'b1);
                        end else begin
                            cnt_d = cnt_q;
                        end
                    end
                end
                default: x_d = x_q;
            endcase
        end else begin
            x_d = x_q;
        end
    end

    // Datapath and result registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x_q        <= {WIDTH{1'b0}};
            y_q        <= {WIDTH{1'b0}};
            k_q        <= {K_W{1'b0}};
            cnt_q      <= {CNT_W{1'b0}};
            gcd_q      <= {WIDTH{1'b0}};
            steps_q    <= {CNT_W{1'b0}};
            zero_err_q <= 1'b0;
        end else begin
            x_q        <= x_d;
            y_q        <= y_d;
            k_q        <= k_d;
            cnt_q      <= cnt_d;
            gcd_q      <= gcd_d;
            steps_q    <= steps_d;
            zero_err_q <= zero_err_d;
        end
    end

endmodule
